textgen: RTL and testbench
==========================

# textgen

Parametrised text-layer generator for the video pipeline. Walks text RAM and font RAM in lockstep with the video timing and produces a 4-bit text colour index per pixel for the compositor. Supports 40/80 columns, 8- or 16-line character cells, a configurable active window, and a hardware cursor with frame-counted blink.

## Interface
Parameters:
- `ADDR_W`, 11: text RAM word address width.
- `CHAR_H`, 8: character cell height in lines; legal values are 8 and 16.
- `VTOP`, 16: first active line (`vline` value).
- `VLINES`, 200: number of active lines; must be a multiple of `CHAR_H`.
- `BLINK_HALF`, 16: frames per cursor blink half-period; must be at least 1.

Ports (widths derived: `FW = 8 + log2(CHAR_H)`):
- `clk`  in  1  pixel clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `reg_mode80`  in  1  80-column mode; sampled only during vblank.
- `reg_cursor_enable`  in  1  cursor on.
- `reg_cursor_blink`  in  1  cursor blinks when set; solid when clear.
- `reg_cursor_addr`  in  ADDR_W  text RAM address of the cursor cell.
- `hpos`  in  10  horizontal pixel position from the timing block.
- `hborder`  in  1  horizontal border or blank.
- `vline`  in  9  current (doubled) line number.
- `vblank`  in  1  vertical blank.
- `vnext`  in  1  one-cycle pulse at the end of each line.
- `tram_addr`  out  ADDR_W  text RAM read address (combinational; RAM registers it).
- `tram_rddata`  in  16  `[7:0]` char code, `[15:8]` colour (fg `[15:12]`, bg `[11:8]`); returned 1 cycle after `tram_addr`.
- `font_addr`  out  FW  `{char, cell_line}` (combinational).
- `font_rddata`  in  8  glyph row, bit 7 leftmost; returned 1 cycle after `font_addr`.
- `text_colidx`  out  4  pixel colour index.
- `text_cursor`  out  1  current pixel lies in a visible cursor cell.

## Operation
- Border condition: `border = hborder || vline < VTOP || vline >= VTOP+VLINES`.
- Vblank:
  - `q_row_addr` and `q_cell_line` are set to 0.
  - `q_mode80` is loaded from `reg_mode80`.
  - `reg_mode80` changes outside vblank are ignored.
- Line advance: on `vnext` with `vline` in `[VTOP, VTOP+VLINES)`, `q_cell_line` increments.
  - At `CHAR_H-1` it wraps to 0 and `q_row_addr += (q_mode80 ? 80 : 40)`, modulo 2^ADDR_W.
- Char address, in priority order:
  1. `border`: all ones.
  2. First non-border cycle (registered border was 1): `q_row_addr`.
  3. Char step (`hpos[2:0]==0` in 80-col, `hpos[3:0]==0` in 40-col): +1.
  4. Otherwise: hold.
  - In 40-col mode the address MSB is forced to 0.
  - `tram_addr` equals this next-address value.
- Font address: `font_addr = {tram_rddata[7:0], q_cell_line}`.
- Pixel select: bit `7 - (80col ? hpos_d2[2:0] : hpos_d2[3:1])`, where `hpos_d2` is `hpos` delayed 2 cycles.
  - Glyph bit 1 selects fg, 0 selects bg. Colour byte is registered once to align with `font_rddata`.
- Cursor hit:
  - Registered char address equals `reg_cursor_addr` and the registered border was 0.
  - The hit is delayed to align with the pixel.
  - Visible when `reg_cursor_enable && (!reg_cursor_blink || q_blink_phase)`.
  - A visible cursor swaps fg and bg, and `text_cursor` is 1.
- Blink counter:
  - Increments on the `vblank` rising edge.
  - At `BLINK_HALF-1` it wraps to 0 and toggles `q_blink_phase`.
- Simultaneous events:
  - `vblank` with `vnext`: vblank wins.
  - `border` with a char step: border wins.

## Timing
- Latency: `text_colidx` and `text_cursor` for inputs presented at cycle N are valid at N+2.
- Reset (synchronous): the following are all 0:
  - `q_row_addr`, `q_cell_line`, `q_mode80`
  - blink counter, `q_blink_phase`
  - colour register
  - `text_cursor`
- Also on reset:
  - Char address register is all ones.
  - `text_colidx` is 0 from the first post-reset cycle until new RAM data propagates (2 cycles).
- Reset mid-frame: content restarts at row 0 and is misaligned until the next vblank realigns it. There is no lockup and no X propagation.
- Row address overflow past 2^ADDR_W wraps silently.
- `CHAR_H=16` with `VLINES=200` is illegal (not a multiple); elaboration must fail.

## Test plan
1. Row stepping: `CHAR_H=8`, 40-col, reset then vblank.
   - Lines 16..23 must read addresses 0..39.
   - Line 24 must start at 40.
   - In 40-col, address bit 10 must always be 0.
2. 80-col address wrap:
   - Set `reg_mode80=1` mid-frame: no change until vblank; the next frame steps by 80.
   - `ADDR_W=11`, 25 rows: last row starts at 1920; no address above 1999 is generated.
3. Pixel output, `CHAR_H=16`:
   - Setup: char 0x41, colour 0x5A, glyph row 0x81 at line 3.
   - `font_addr` must be 0x413.
   - `text_colidx` must be 5 for the first/last pixel pair and 0xA in between, 2 cycles after `hpos`.
4. Cursor, steady:
   - Setup: cursor at address 42, blink off, colour 0x5A.
   - Cell 42 must show fg/bg swapped (0xA/5) with `text_cursor=1`; neighbours are unswapped.
   - With `reg_cursor_enable=0`: no swap.
5. Cursor blink: `BLINK_HALF=2`, blink on.
   - The cursor must be hidden for frames 0–1, visible for 2–3, hidden for 4–5.
   - Reset mid-frame returns the phase to hidden.
6. Border and simultaneous events:
   - During border, `tram_addr=0x7FF` and there is no cursor hit at `reg_cursor_addr=0x7FF`.
   - `vnext` coincident with `vblank` must leave row and line at 0.

Source files
------------

// File: rtl/textgen.sv
// ============================================================================
// textgen -- text-layer generator: walks text/font RAM with video timing and
//            emits a 4-bit colour index per pixel plus a cursor flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module textgen #(
  parameter int ADDR_W     = 11,
  parameter int CHAR_H     = 8,
  parameter int VTOP       = 16,
  parameter int VLINES     = 200,
  parameter int BLINK_HALF = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            reg_mode80,
  input  logic                            reg_cursor_enable,
  input  logic                            reg_cursor_blink,
  input  logic [ADDR_W-1:0]               reg_cursor_addr,
  input  logic [9:0]                      hpos,
  input  logic                            hborder,
  input  logic [8:0]                      vline,
  input  logic                            vblank,
  input  logic                            vnext,
  output logic [ADDR_W-1:0]               tram_addr,
  input  logic [15:0]                     tram_rddata,
  output logic [8+$clog2(CHAR_H)-1:0]     font_addr,
  input  logic [7:0]                      font_rddata,
  output logic [3:0]                      text_colidx,
  output logic                            text_cursor
);

  localparam int LW = $clog2(CHAR_H);
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [9:0]    c_VTOP       = 10'(VTOP);
  localparam logic [9:0]    c_VEND       = 10'(VTOP + VLINES);
  localparam logic [LW-1:0] c_LAST_LINE  = LW'(CHAR_H - 1);
  localparam logic [CW-1:0] c_BLINK_LAST = CW'(BLINK_HALF - 1);

  generate
    if (!(CHAR_H == 8 || CHAR_H == 16) || (VLINES % CHAR_H) != 0 || BLINK_HALF < 1) begin : g_bad_params
      $error("textgen: illegal CHAR_H / VLINES / BLINK_HALF combination");
    end
  endgenerate

  logic [ADDR_W-1:0] r_row_addr;
  logic [LW-1:0]     r_cell_line;
  logic              r_mode80;
  logic [ADDR_W-1:0] r_char_addr;
  logic              r_border;
  logic [3:0]        r_hpos_d1;
  logic [3:0]        r_hpos_d2;
  logic [7:0]        r_colour;
  logic              r_hit_d;
  logic              r_vblank_d;
  logic [CW-1:0]     r_blink_cnt;
  logic              r_blink_phase;

  logic              w_vactive;
  logic              w_border;
  logic              w_char_step;
  logic [ADDR_W-1:0] w_row_step;
  logic [ADDR_W-1:0] w_char_next;
  logic              w_hit;
  logic [2:0]        w_bit_idx;
  logic              w_glyph;
  logic              w_cursor_vis;
  logic              w_unused;

  assign w_unused   = &{1'b0, hpos[9:4]};
  assign w_vactive  = ({1'b0, vline} >= c_VTOP) && ({1'b0, vline} < c_VEND);
  assign w_border   = hborder || !w_vactive;
  assign w_row_step = r_mode80 ? ADDR_W'(80) : ADDR_W'(40);

  // Row/line tracking; vblank takes precedence over a coincident vnext.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_addr  <= '0;
      r_cell_line <= '0;
      r_mode80    <= 1'b0;
    end else if (vblank) begin
      r_row_addr  <= '0;
      r_cell_line <= '0;
      r_mode80    <= reg_mode80;
    end else if (vnext && w_vactive) begin
      if (r_cell_line == c_LAST_LINE) begin
        r_cell_line <= '0;
        r_row_addr  <= r_row_addr + w_row_step;
      end else begin
        r_cell_line <= r_cell_line + LW'(1);
      end
    end
  end

  always_comb begin
    w_char_step = r_mode80 ? (hpos[2:0] == 3'd0) : (hpos[3:0] == 4'd0);
    if (w_border)
      w_char_next = '1;
    else if (r_border)
      w_char_next = r_row_addr;
    else if (w_char_step)
      w_char_next = r_char_addr + ADDR_W'(1);
    else
      w_char_next = r_char_addr;
    if (!r_mode80)
      w_char_next[ADDR_W-1] = 1'b0;
  end

  assign tram_addr = w_char_next;
  assign font_addr = {tram_rddata[7:0], r_cell_line};
  assign w_hit     = (r_char_addr == reg_cursor_addr) && !r_border;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_char_addr   <= '1;
      r_border      <= 1'b1;
      r_hpos_d1     <= '0;
      r_hpos_d2     <= '0;
      r_colour      <= '0;
      r_hit_d       <= 1'b0;
      r_vblank_d    <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_char_addr <= w_char_next;
      r_border    <= w_border;
      r_hpos_d1   <= hpos[3:0];
      r_hpos_d2   <= r_hpos_d1;
      r_colour    <= tram_rddata[15:8];
      r_hit_d     <= w_hit;
      r_vblank_d  <= vblank;
      if (vblank && !r_vblank_d) begin
        if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + CW'(1);
        end
      end
    end
  end

  // A visible cursor inverts the glyph bit, which swaps fg and bg.
  assign w_bit_idx    = r_mode80 ? r_hpos_d2[2:0] : r_hpos_d2[3:1];
  assign w_glyph      = font_rddata[3'd7 - w_bit_idx];
  assign w_cursor_vis = reg_cursor_enable && (!reg_cursor_blink || r_blink_phase);
  assign text_cursor  = r_hit_d && w_cursor_vis;
  assign text_colidx  = (w_glyph ^ text_cursor) ? r_colour[7:4] : r_colour[3:0];

endmodule

`default_nettype wire

// File: tb/tb_textgen.sv
// ============================================================================
// tb_textgen -- directed, table-driven bench for textgen (8- and 16-line cells).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_textgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reg_mode80, reg_cursor_enable, reg_cursor_blink;
  logic [10:0] reg_cursor_addr;
  logic [9:0]  hpos;
  logic        hborder, vblank, vnext;
  logic [8:0]  vline;
  logic [10:0] tram_addr, tram_addr16;
  logic [15:0] tram_rd, tram_rd16;
  logic [10:0] font_addr;
  logic [11:0] font_addr16;
  logic [7:0]  font_rd, font_rd16;
  logic [3:0]  colidx, colidx16;
  logic        cursor, cursor16;

  textgen #(.ADDR_W(11), .CHAR_H(8), .VTOP(16), .VLINES(200), .BLINK_HALF(2)) u_dut (
    .clk(clk), .reset(reset), .reg_mode80(reg_mode80),
    .reg_cursor_enable(reg_cursor_enable), .reg_cursor_blink(reg_cursor_blink),
    .reg_cursor_addr(reg_cursor_addr), .hpos(hpos), .hborder(hborder),
    .vline(vline), .vblank(vblank), .vnext(vnext),
    .tram_addr(tram_addr), .tram_rddata(tram_rd),
    .font_addr(font_addr), .font_rddata(font_rd),
    .text_colidx(colidx), .text_cursor(cursor));

  textgen #(.ADDR_W(11), .CHAR_H(16), .VTOP(16), .VLINES(192), .BLINK_HALF(16)) u_dut16 (
    .clk(clk), .reset(reset), .reg_mode80(reg_mode80),
    .reg_cursor_enable(reg_cursor_enable), .reg_cursor_blink(reg_cursor_blink),
    .reg_cursor_addr(reg_cursor_addr), .hpos(hpos), .hborder(hborder),
    .vline(vline), .vblank(vblank), .vnext(vnext),
    .tram_addr(tram_addr16), .tram_rddata(tram_rd16),
    .font_addr(font_addr16), .font_rddata(font_rd16),
    .text_colidx(colidx16), .text_cursor(cursor16));

  // RAM models: every text cell holds char 0x41, colour 0x5A.
  always_ff @(posedge clk) begin
    tram_rd   <= (tram_addr   == 11'h7FF) ? 16'h5A41 : 16'h5A41;
    tram_rd16 <= (tram_addr16 == 11'h7FF) ? 16'h5A41 : 16'h5A41;
    font_rd   <= (font_addr[10:3] == 8'h41) ? 8'hF0 : 8'h00;
    font_rd16 <= (font_addr16 == 12'h413) ? 8'h81 : 8'h00;
  end

  typedef struct {
    int h;
    int col;
    int cur;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cap_addr[640], cap_addr16[640], cap_fa8[640], cap_fa16[640];
  int   cap_col[640], cap_col16[640], cap_cur[640];
  int   d1 = -1, d2 = -1;
  int   border_addr = 0;
  int   cur_vline = 0;
  logic cur_vblank = 1'b0;
  logic any_cur = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int h, input logic hb, input logic vn);
    @(posedge clk); #1;
    hpos = 10'(h); hborder = hb; vnext = vn;
    vline = 9'(cur_vline); vblank = cur_vblank;
    @(negedge clk);
    if (!hb) begin
      cap_addr[h]   = int'(tram_addr);
      cap_addr16[h] = int'(tram_addr16);
      cap_fa8[h]    = int'(font_addr);
      cap_fa16[h]   = int'(font_addr16);
    end else begin
      border_addr = int'(tram_addr);
    end
    if (d2 >= 0) begin
      cap_col[d2]   = int'(colidx);
      cap_col16[d2] = int'(colidx16);
      cap_cur[d2]   = int'(cursor);
    end
    any_cur = any_cur | cursor;
    d2 = d1;
    d1 = hb ? -1 : h;
  endtask

  task automatic run_line(input int vl, input bit full);
    cur_vline = vl;
    if (full)
      for (int h = 0; h < 640; h++) step(h, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(640 + i, 1'b1, 1'b0);
    step(700, 1'b1, 1'b1);
  endtask

  task automatic short_lines(input int from, input int to);
    for (int vl = from; vl < to; vl++) run_line(vl, 1'b0);
  endtask

  // vblank with vline inside the active window and vnext on its last cycle.
  task automatic do_vblank();
    cur_vblank = 1'b1;
    cur_vline  = 20;
    for (int i = 0; i < 3; i++) step(700, 1'b1, 1'b0);
    step(700, 1'b1, 1'b1);
    cur_vblank = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1;
    reset = 1'b1; hborder = 1'b1; vnext = 1'b0; vblank = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, "_colidx_in_reset"}, int'(colidx), 0);
    chk({nm, "_cursor_in_reset"}, int'(cursor), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk({nm, "_colidx_post_reset"}, int'(colidx), 0);
    chk({nm, "_colidx16_post_reset"}, int'(colidx16), 0);
    d1 = -1; d2 = -1;
  endtask

  task automatic chk_addr_line(input string nm, input int base, input int shift, input bit is16);
    int bad = -1;
    int idx;
    for (int h = 0; h < 640; h++)
      if (bad < 0 && (is16 ? cap_addr16[h] : cap_addr[h]) != base + (h >> shift)) bad = h;
    idx = (bad < 0) ? 0 : bad;
    chk($sformatf("%s@h%0d", nm, idx), is16 ? cap_addr16[idx] : cap_addr[idx], base + (idx >> shift));
  endtask

  task automatic apply_tbl(input string nm, input bit is16);
    foreach (tbl[i]) begin
      if (is16) begin
        chk($sformatf("%s_col16@h%0d", nm, tbl[i].h), cap_col16[tbl[i].h], tbl[i].col);
      end else begin
        chk($sformatf("%s_col@h%0d", nm, tbl[i].h), cap_col[tbl[i].h], tbl[i].col);
        chk($sformatf("%s_cur@h%0d", nm, tbl[i].h), cap_cur[tbl[i].h], tbl[i].cur);
      end
    end
  endtask

  initial begin
    int b10;
    int amax;
    int exp_vis;
    reset = 1'b0; reg_mode80 = 1'b0; reg_cursor_enable = 1'b0; reg_cursor_blink = 1'b0;
    reg_cursor_addr = '0; hpos = '0; hborder = 1'b1; vline = '0; vblank = 1'b0; vnext = 1'b0;

    do_reset("rst");

    // Frame A: 40 columns; reg_mode80 raised mid-frame must not take effect yet.
    do_vblank();
    short_lines(0, 16);
    reg_mode80 = 1'b1;
    reg_cursor_addr = 11'd42; reg_cursor_enable = 1'b1; reg_cursor_blink = 1'b0;
    b10 = 0;
    for (int vl = 16; vl < 24; vl++) begin
      run_line(vl, 1'b1);
      chk_addr_line($sformatf("row0_line%0d", vl), 0, 4, 1'b0);
      for (int h = 0; h < 640; h++) b10 = b10 | ((cap_addr[h] >> 10) & 1);
      if (vl == 16) chk("cell_line_after_vblank_vnext", cap_fa8[100] & 7, 0);
      if (vl == 19) begin
        chk("font_addr16_line3", cap_fa16[100], 12'h413);
        chk_addr_line("row0_dut16", 0, 4, 1'b1);
        tbl.delete();
        tbl.push_back('{h:0,   col:5,  cur:0}); tbl.push_back('{h:1,   col:5,  cur:0});
        tbl.push_back('{h:2,   col:10, cur:0}); tbl.push_back('{h:7,   col:10, cur:0});
        tbl.push_back('{h:13,  col:10, cur:0}); tbl.push_back('{h:14,  col:5,  cur:0});
        tbl.push_back('{h:15,  col:5,  cur:0}); tbl.push_back('{h:16,  col:5,  cur:0});
        tbl.push_back('{h:18,  col:10, cur:0}); tbl.push_back('{h:637, col:10, cur:0});
        tbl.push_back('{h:638, col:5,  cur:0}); tbl.push_back('{h:639, col:5,  cur:0});
        apply_tbl("pix16", 1'b1);
      end
    end
    run_line(24, 1'b1);
    chk_addr_line("row1_line24", 40, 4, 1'b0);
    for (int h = 0; h < 640; h++) b10 = b10 | ((cap_addr[h] >> 10) & 1);
    chk("bit10_in_40col", b10, 0);
    tbl.delete();
    tbl.push_back('{h:16, col:5,  cur:0}); tbl.push_back('{h:24, col:10, cur:0});
    tbl.push_back('{h:31, col:10, cur:0}); tbl.push_back('{h:32, col:10, cur:1});
    tbl.push_back('{h:39, col:10, cur:1}); tbl.push_back('{h:40, col:5,  cur:1});
    tbl.push_back('{h:47, col:5,  cur:1}); tbl.push_back('{h:48, col:5,  cur:0});
    apply_tbl("cursor_on", 1'b0);
    reg_cursor_enable = 1'b0;
    run_line(25, 1'b1);
    tbl.delete();
    tbl.push_back('{h:32, col:5,  cur:0}); tbl.push_back('{h:40, col:10, cur:0});
    tbl.push_back('{h:44, col:10, cur:0});
    apply_tbl("cursor_off", 1'b0);
    short_lines(26, 240);

    // Frame B: 80 columns now latched.
    do_vblank();
    short_lines(0, 16);
    run_line(16, 1'b1);
    chk_addr_line("m80_row0", 0, 3, 1'b0);
    short_lines(17, 24);
    run_line(24, 1'b1);
    chk_addr_line("m80_row1", 80, 3, 1'b0);
    reg_cursor_addr = 11'h7FF; reg_cursor_enable = 1'b1;
    short_lines(25, 208);
    any_cur = 1'b0;
    run_line(208, 1'b1);
    chk_addr_line("m80_row24", 1920, 3, 1'b0);
    amax = 0;
    for (int h = 0; h < 640; h++) if (cap_addr[h] > amax) amax = cap_addr[h];
    chk("m80_max_addr", amax, 1999);
    chk("border_addr", border_addr, 11'h7FF);
    chk("no_cursor_hit_7ff", int'(any_cur), 0);
    short_lines(209, 240);

    // Blink: BLINK_HALF=2, cursor on cell 0.
    reg_mode80 = 1'b0; reg_cursor_addr = 11'd0; reg_cursor_enable = 1'b1; reg_cursor_blink = 1'b1;
    do_reset("blink_rst");
    for (int k = 0; k < 7; k++) begin
      if (k > 0) do_vblank();
      run_line(16, 1'b1);
      exp_vis = ((k / 2) % 2 == 1) ? 1 : 0;
      chk($sformatf("blink_cur_frame%0d", k), cap_cur[4], exp_vis);
      chk($sformatf("blink_col_frame%0d", k), cap_col[4], (exp_vis == 1) ? 10 : 5);
    end
    do_reset("midframe_rst");
    run_line(16, 1'b1);
    chk("blink_cur_after_reset", cap_cur[4], 0);
    chk("blink_col_after_reset", cap_col[4], 5);
    chk_addr_line("row0_after_reset", 0, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
